// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_pkg
// Brief    : Op encodings, FSM state encoding and flag bundle for seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_BUSY = 2'd1;
    localparam state_t c_DONE = 2'd2;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic dbz;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_divmod.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_divmod
// Brief    : Iterative restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_divmod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    logic             r_active;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // Dividend bits are shifted out of the quotient register as quotient bits enter.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_fits    = ~w_trial[WIDTH];
    assign remainder = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quotient  = {r_quo[WIDTH-2:0], w_fits};
    // Outputs carry the final values during the cycle done is high.
    assign done      = r_active && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= dividend;
            r_div    <= divisor;
        end else if (r_active) begin
            r_rem <= remainder;
            r_quo <= quotient;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Handshaked sequential ALU: add/sub, shift-add multiply, div/mod.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    flags_t             r_flags;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_div_start;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_div_res;

    assign w_sum       = {1'b0, a} + {1'b0, b};
    assign w_diff      = {1'b0, a} - {1'b0, b};
    assign w_add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_div_start = in_valid && (r_state == c_IDLE) &&
                         ((op == OP_DIV) || (op == OP_MOD)) && (b != '0);
    assign w_div_res   = (r_op == OP_DIV) ? w_quo : w_rem;

    seq_alu_divmod #(
        .WIDTH(WIDTH)
    ) u_divmod (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (a),
        .divisor  (b),
        .done     (w_div_done),
        .quotient (w_quo),
        .remainder(w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_flags  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        case (op)
                            OP_SUB: begin
                                r_result <= w_diff[WIDTH-1:0];
                                r_flags  <= '{carry: w_diff[WIDTH], ovf: w_sub_ovf,
                                              zero: (w_diff[WIDTH-1:0] == '0), dbz: 1'b0};
                                r_state  <= c_DONE;
                            end
                            OP_MUL: begin
                                r_acc    <= '0;
                                r_mcand  <= {{WIDTH{1'b0}}, a};
                                r_mplier <= b;
                                r_state  <= c_BUSY;
                            end
                            OP_DIV, OP_MOD: begin
                                if (b == '0) begin
                                    r_result <= (op == OP_DIV) ? '1 : a;
                                    r_flags  <= '{carry: 1'b0, ovf: 1'b0,
                                                  zero: (op == OP_MOD) && (a == '0), dbz: 1'b1};
                                    r_state  <= c_DONE;
                                end else begin
                                    r_state <= c_BUSY;
                                end
                            end
                            default: begin
                                r_result <= w_sum[WIDTH-1:0];
                                r_flags  <= '{carry: w_sum[WIDTH], ovf: w_add_ovf,
                                              zero: (w_sum[WIDTH-1:0] == '0), dbz: 1'b0};
                                r_state  <= c_DONE;
                            end
                        endcase
                    end
                end
                c_BUSY: begin
                    if (r_op == OP_MUL) begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_result <= w_acc_next[WIDTH-1:0];
                            r_flags  <= '{carry: (w_acc_next[2*WIDTH-1:WIDTH] != '0),
                                          ovf:   (w_acc_next[2*WIDTH-1:WIDTH] != '0),
                                          zero:  (w_acc_next[WIDTH-1:0] == '0), dbz: 1'b0};
                            r_state  <= c_DONE;
                        end
                    end else if (w_div_done) begin
                        r_result <= w_div_res;
                        r_flags  <= '{carry: 1'b0, ovf: 1'b0, zero: (w_div_res == '0), dbz: 1'b0};
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign carry     = r_flags.carry;
    assign ovf       = r_flags.ovf;
    assign zero      = r_flags.zero;
    assign dbz       = r_flags.dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         dbz;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .ovf      (ovf),
        .zero     (zero),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer math on the operands.
    function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] r, output logic [3:0] f, output int lat);
        int ua, ub, sa, sb, s, smax, smin;
        logic c, o, d;
        ua = int'(ma); ub = int'(mb);
        sa = $signed(ma); sb = $signed(mb);
        smax = 2**(W-1) - 1; smin = -(2**(W-1));
        c = 1'b0; o = 1'b0; d = 1'b0; lat = 1;
        case (mop)
            4'd1: begin
                s = ua - ub; r = s[W-1:0]; c = (ua < ub);
                o = (sa - sb > smax) || (sa - sb < smin);
            end
            4'd2: begin
                s = ua * ub; r = s[W-1:0]; c = ((s >> W) != 0); o = c; lat = W + 1;
            end
            4'd3: begin
                if (ub == 0) begin r = '1; d = 1'b1; end
                else begin s = ua / ub; r = s[W-1:0]; lat = W + 1; end
            end
            4'd4: begin
                if (ub == 0) begin r = ma; d = 1'b1; end
                else begin s = ua % ub; r = s[W-1:0]; lat = W + 1; end
            end
            default: begin
                s = ua + ub; r = s[W-1:0]; c = (s >= 2**W);
                o = (sa + sb > smax) || (sa + sb < smin);
            end
        endcase
        f = {c, o, (r == '0), d};
    endfunction

    logic         have_exp = 1'b0;
    logic         seen = 1'b0;
    int           acc_cyc = 0;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;
    int           m_lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_exp = 1'b0;
        end else begin
            if (out_valid) begin
                if (!have_exp) begin
                    check("mdl_spurious_valid", out_valid, 0);
                end else begin
                    check("mdl_result", result, m_res);
                    check("mdl_flags", {carry, ovf, zero, dbz}, m_flags);
                    check("mdl_ready_in_done", in_ready, 0);
                    if (!seen) check("mdl_latency", cyc - acc_cyc, m_lat);
                    seen = 1'b1;
                    if (out_ready) have_exp = 1'b0;
                end
            end else if (have_exp) begin
                check("mdl_ready_in_busy", in_ready, 0);
            end else begin
                check("mdl_ready_idle", in_ready, 1);
            end
            if (in_valid && in_ready) begin
                model(op, a, b, m_res, m_flags, m_lat);
                have_exp = 1'b1;
                seen = 1'b0;
                acc_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [3:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb);
        @(posedge clk); #1;
        op = top; a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm, input logic [W-1:0] er, input logic [3:0] ef, input int el);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_result"}, result, er);
        check({nm, "_flags"}, {carry, ovf, zero, dbz}, ef);
        check({nm, "_latency"}, lat, el);
    endtask

    task automatic release_out(input string nm);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check({nm, "_ready_next"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run(input string nm, input logic [3:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] er, input logic [3:0] ef, input int el);
        send(top, ta, tb);
        wait_res(nm, er, ef, el);
        release_out(nm);
    endtask

    initial begin
        @(negedge clk);
        check("reset_outputs", {out_valid, in_ready, carry, ovf, zero, dbz}, 6'b010000);
        check("reset_result", result, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // flags are {carry, ovf, zero, dbz}
        run("add_200_100", 4'd0, 8'd200, 8'd100, 8'd44,  4'b1000, 1);
        run("sub_5_7",     4'd1, 8'd5,   8'd7,   8'd254, 4'b1000, 1);
        run("sub_128_1",   4'd1, 8'd128, 8'd1,   8'd127, 4'b0100, 1);
        run("add_127_1",   4'd0, 8'd127, 8'd1,   8'd128, 4'b0100, 1);
        run("add_255_1",   4'd0, 8'd255, 8'd1,   8'd0,   4'b1010, 1);
        run("op15_as_add", 4'd15, 8'd1,  8'd2,   8'd3,   4'b0000, 1);
        run("mul_20_15",   4'd2, 8'd20,  8'd15,  8'd44,  4'b1100, 9);
        run("mul_0_255",   4'd2, 8'd0,   8'd255, 8'd0,   4'b0010, 9);
        run("mul_15_17",   4'd2, 8'd15,  8'd17,  8'd255, 4'b0000, 9);
        run("div_200_7",   4'd3, 8'd200, 8'd7,   8'd28,  4'b0000, 9);
        run("mod_200_7",   4'd4, 8'd200, 8'd7,   8'd4,   4'b0000, 9);
        run("div_255_1",   4'd3, 8'd255, 8'd1,   8'd255, 4'b0000, 9);
        run("mod_5_9",     4'd4, 8'd5,   8'd9,   8'd5,   4'b0000, 9);
        run("div_3_9",     4'd3, 8'd3,   8'd9,   8'd0,   4'b0010, 9);
        run("div_9_0",     4'd3, 8'd9,   8'd0,   8'd255, 4'b0001, 1);
        run("mod_9_0",     4'd4, 8'd9,   8'd0,   8'd9,   4'b0001, 1);

        // Backpressure with a competing request held during DONE
        send(4'd2, 8'd20, 8'd15);
        wait_res("bp_mul", 8'd44, 4'b1100, 9);
        @(posedge clk); #1;
        op = 4'd0; a = 8'd3; b = 8'd4; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_result", result, 44);
            check("bp_hold_flags", {carry, ovf, zero, dbz}, 4'b1100);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_next", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_res("bp_held_add", 8'd7, 4'b0000, 1);
        release_out("bp_held_add");

        // Asynchronous reset in the middle of a multiply
        send(4'd2, 8'd20, 8'd15);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {out_valid, in_ready, carry, ovf, zero, dbz}, 6'b010000);
        check("rst_mid_result", result, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_late_valid", out_valid, 0);
        run("post_rst_add", 4'd0, 8'd1, 8'd1, 8'd2, 4'b0000, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
